// File: rtl/maf_stage_pkg.sv
// Shared types and helpers for the FMA compression / leading-zero stage.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package maf_stage_pkg;

  // Operating mode carried with every beat
  typedef enum logic [1:0] {
    MODE_SINGLE  = 2'b00,
    MODE_PACKED  = 2'b01,
    MODE_MULONLY = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // Bits needed to hold a leading-zero count of 0..n inclusive
  function automatic int lzc_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/maf_lzc.sv
// Exact leading-zero counter of width N; an all-zero input yields N.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module maf_lzc
  import maf_stage_pkg::*;
#(
  parameter int N  = 24,
  parameter int CW = lzc_w(N)
) (
  input  logic [N-1:0]  x,
  output logic [CW-1:0] cnt
);

  // Scan upward so the highest set bit writes last and wins
  always_comb begin
    cnt = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (x[i]) begin
        cnt = CW'(N - 1 - i);
      end
    end
  end

endmodule

// File: rtl/maf_csa_lza_stage.sv
// 3:2 compression of multiplier sum/carry with the aligned addend, per-lane subtract and exact LZ count.
// Latency: 1 cycle accept-to-out_valid; 1 beat/cycle with out_ready held high.
// Backpressure: main + skid register hold up to 2 beats; in_ready is registered and drops once skid fills.
module maf_csa_lza_stage
  import maf_stage_pkg::*;
#(
  parameter int W     = 48,
  parameter int LANES = 2,
  parameter int SB_W  = 32,
  parameter int LZC_W = lzc_w(W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [W-1:0]             in_sum,
  input  logic [W-1:0]             in_carry,
  input  logic [W-1:0]             in_addend,
  input  logic [LANES-1:0]         in_sub,
  input  logic [SB_W-1:0]          in_side,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_mode,
  output logic [W-1:0]             out_sum,
  output logic [W:0]               out_carry,
  output logic [LANES*LZC_W-1:0]   out_lz,
  output logic                     out_illegal,
  output logic [SB_W-1:0]          out_side
);

  localparam int LW     = W / LANES;
  localparam int LANE_Z = lzc_w(LW);
  localparam int FULL_Z = lzc_w(W);

  // One registered beat: everything the downstream stage sees
  typedef struct packed {
    logic [1:0]             mode;
    logic [W-1:0]           sum;
    logic [W:0]             carry;
    logic [LANES*LZC_W-1:0] lz;
    logic                   illegal;
    logic [SB_W-1:0]        side;
  } beat_t;

  mode_e                          mode;
  logic                           use_addend;
  logic [LANES-1:0]               sub_eff;
  logic [W-1:0]                   c_vec;
  logic [W-1:0]                   maj;
  logic [W-1:0]                   csa_sum;
  logic [W:0]                     csa_carry;
  logic [W-1:0]                   r_full;
  logic [LANES-1:0][LANE_Z-1:0]   lane_lz;
  logic [FULL_Z-1:0]              full_lz;
  logic [LANES*LZC_W-1:0]         lz_sel;
  beat_t                          new_beat;

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  logic  main_vld_q, main_vld_d;
  logic  skid_vld_q, skid_vld_d;
  logic  in_rdy_q, in_rdy_d;
  logic  accept;
  logic  drain;

  assign mode = mode_e'(in_mode);

  // Resolve per-lane subtraction and build the (possibly inverted) addend operand
  always_comb begin
    sub_eff    = '0;
    use_addend = 1'b0;
    c_vec      = '0;
    case (mode)
      MODE_SINGLE: begin
        sub_eff    = {LANES{in_sub[0]}};
        use_addend = 1'b1;
      end
      MODE_PACKED: begin
        sub_eff    = in_sub;
        use_addend = 1'b1;
      end
      default: ;
    endcase
    if (use_addend) begin
      for (int k = 0; k < LANES; k++) begin
        c_vec[k*LW +: LW] = sub_eff[k] ? ~in_addend[k*LW +: LW] : in_addend[k*LW +: LW];
      end
    end
  end

  // Segmented 3:2 compressor; in packed mode the lane-boundary carry slot holds that lane's +1
  always_comb begin
    csa_sum   = in_sum ^ in_carry ^ c_vec;
    maj       = (in_sum & in_carry) | (in_sum & c_vec) | (in_carry & c_vec);
    csa_carry = {maj, sub_eff[0]};
    if (mode == MODE_PACKED) begin
      for (int k = 1; k < LANES; k++) begin
        csa_carry[k*LW] = sub_eff[k];
      end
    end
  end

  // Full-width result used by single, multiply-only and reserved modes
  assign r_full = csa_sum + csa_carry[W-1:0];

  maf_lzc #(.N(W), .CW(FULL_Z)) u_lzc_full (
    .x   (r_full),
    .cnt (full_lz)
  );

  // Per-lane adders wrap modulo the lane width so nothing leaks across lanes
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LW-1:0] r_lane;
    assign r_lane = csa_sum[g*LW +: LW] + csa_carry[g*LW +: LW];
    maf_lzc #(.N(LW), .CW(LANE_Z)) u_lzc_lane (
      .x   (r_lane),
      .cnt (lane_lz[g])
    );
  end

  // Pick lane or full-width counts and assemble the beat to be captured
  always_comb begin
    lz_sel = '0;
    if (mode == MODE_PACKED) begin
      for (int k = 0; k < LANES; k++) begin
        lz_sel[k*LZC_W +: LZC_W] = LZC_W'(lane_lz[k]);
      end
    end else begin
      lz_sel[LZC_W-1:0] = LZC_W'(full_lz);
    end
    new_beat.mode    = in_mode;
    new_beat.sum     = csa_sum;
    new_beat.carry   = csa_carry;
    new_beat.lz      = lz_sel;
    new_beat.illegal = (mode == MODE_RSVD);
    new_beat.side    = in_side;
  end

  // Skid buffer: new beats fill main when it is free or draining, else skid; flush wins over all
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    accept     = in_valid & in_rdy_q;
    drain      = main_vld_q & out_ready;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drain) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = accept;
        if (accept) begin
          skid_d = new_beat;
        end
      end else begin
        main_vld_d = accept;
        if (accept) begin
          main_d = new_beat;
        end
      end
    end else if (accept) begin
      skid_d     = new_beat;
      skid_vld_d = 1'b1;
    end
    in_rdy_d = !skid_vld_d;
  end

  // State registers; reset clears data too so every output reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_ready    = in_rdy_q;
  assign out_valid   = main_vld_q;
  assign out_mode    = main_q.mode;
  assign out_sum     = main_q.sum;
  assign out_carry   = main_q.carry;
  assign out_lz      = main_q.lz;
  assign out_illegal = main_q.illegal;
  assign out_side    = main_q.side;

endmodule

// File: tb/tb_maf_csa_lza_stage.sv
module tb_maf_csa_lza_stage;

  typedef struct packed {
    logic [1:0]  mode;
    logic [47:0] sum;
    logic [48:0] carry;
    logic [11:0] lz;
    logic        ill;
    logic [31:0] side;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [1:0]  in_mode, in_sub, out_mode;
  logic [47:0] in_sum, in_carry, in_addend, out_sum;
  logic [48:0] out_carry;
  logic [11:0] out_lz;
  logic [31:0] in_side, out_side;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t exp_q[$];
  beat_t got_q[$];

  always #5 clk = ~clk;

  maf_csa_lza_stage #(.W(48), .LANES(2), .SB_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_sum(in_sum), .in_carry(in_carry), .in_addend(in_addend),
    .in_sub(in_sub), .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_sum(out_sum), .out_carry(out_carry), .out_lz(out_lz),
    .out_illegal(out_illegal), .out_side(out_side)
  );

  function automatic int clz(input logic [63:0] v, input int n);
    int z;
    z = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (v[i]) return z;
      z++;
    end
    return z;
  endfunction

  // Reference: operand rules from the block description, result by plain integer addition
  function automatic beat_t model(input logic [1:0] m, input logic [47:0] s, input logic [47:0] ci,
                                  input logic [47:0] a, input logic [1:0] sb, input logic [31:0] sd);
    beat_t       e;
    logic [1:0]  se;
    logic [47:0] c;
    logic [48:0] cy;
    logic [63:0] t;
    se = (m == 2'b00) ? {2{sb[0]}} : (m == 2'b01) ? sb : 2'b00;
    if (m[1]) c = '0;
    else c = {se[1] ? ~a[47:24] : a[47:24], se[0] ? ~a[23:0] : a[23:0]};
    cy = {(s & ci) | (s & c) | (ci & c), se[0]};
    if (m == 2'b01) cy[24] = se[1];
    e.mode  = m;
    e.sum   = s ^ ci ^ c;
    e.carry = cy;
    e.lz    = '0;
    if (m == 2'b01) begin
      for (int k = 0; k < 2; k++) begin
        t = 64'(s[k*24 +: 24]) + 64'(ci[k*24 +: 24]) + 64'(c[k*24 +: 24]) + 64'(se[k]);
        e.lz[k*6 +: 6] = 6'(clz(t, 24));
      end
    end else begin
      t = 64'(s) + 64'(ci) + 64'(c) + 64'(se[0]);
      e.lz[5:0] = 6'(clz(t, 48));
    end
    e.ill  = (m == 2'b11);
    e.side = sd;
    return e;
  endfunction

  function automatic beat_t cur_out();
    beat_t b;
    b.mode = out_mode; b.sum = out_sum; b.carry = out_carry;
    b.lz = out_lz; b.ill = out_illegal; b.side = out_side;
    return b;
  endfunction

  // Capture accepted inputs (as modelled results) and delivered outputs, mid-cycle
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_sum, in_carry, in_addend, in_sub, in_side));
      if (out_valid && out_ready) got_q.push_back(cur_out());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [1:0] m, input logic [47:0] s, input logic [47:0] ci,
                          input logic [47:0] a, input logic [1:0] sb, input logic [31:0] sd);
    in_mode = m; in_sum = s; in_carry = ci; in_addend = a; in_sub = sb; in_side = sd;
  endtask

  task automatic rand_beat();
    set_beat(2'($urandom), 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
             48'({$urandom(), $urandom()}), 2'($urandom), $urandom());
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_beat(2'b00, '0, '0, '0, 2'b00, '0);
    step(); step();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_hs: valid/ready=%b required 00", {out_valid, in_ready});
    end
    n_cmp++;
    if (cur_out() !== beat_t'(0)) begin
      n_bad++; $display("FAIL reset_data: got %h required 0", cur_out());
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL reset_release: valid/ready=%b required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    // single, trivial
    set_beat(2'b00, 48'd1, 48'd0, 48'd0, 2'b00, 32'hA5A5_0001); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_sum, out_carry, out_lz, out_side} !== {1'b1, 48'd1, 49'd0, 6'd0, 6'd47, 32'hA5A5_0001}) begin
      n_bad++; $display("FAIL single_one: v=%b sum=%h carry=%h lz=%h side=%h required v=1 sum=1 carry=0 lz1=0 lz0=47",
                        out_valid, out_sum, out_carry, out_lz, out_side);
    end
    // single, subtract: 5 - 3 = 2
    set_beat(2'b00, 48'd5, 48'd0, 48'd3, 2'b01, 32'd2); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    n_cmp++;
    if (out_lz !== {6'd0, 6'd46}) begin
      n_bad++; $display("FAIL single_sub_lz: lz=%h required %h", out_lz, {6'd0, 6'd46});
    end
    n_cmp++;
    if (cur_out() !== model(2'b00, 48'd5, 48'd0, 48'd3, 2'b01, 32'd2)) begin
      n_bad++; $display("FAIL single_sub_vec: got %h required %h", cur_out(), model(2'b00, 48'd5, 48'd0, 48'd3, 2'b01, 32'd2));
    end
    // packed, lane 0 wraps to zero without carrying into lane 1
    set_beat(2'b01, {24'h000010, 24'hFFFFFF}, 48'd0, {24'h0, 24'h000001}, 2'b00, 32'd3); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    n_cmp++;
    if (out_lz !== {6'd19, 6'd24}) begin
      n_bad++; $display("FAIL packed_lz: lz1=%0d lz0=%0d required lz1=19 lz0=24", out_lz[11:6], out_lz[5:0]);
    end
    // reserved mode: addend and sub ignored, flagged illegal
    set_beat(2'b11, 48'h123, 48'd0, {48{1'b1}}, 2'b11, 32'd4); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    n_cmp++;
    if ({out_illegal, out_mode, out_carry[0], out_sum, out_lz} !== {1'b1, 2'b11, 1'b0, 48'h123, 6'd0, 6'd39}) begin
      n_bad++; $display("FAIL rsvd_mode: ill=%b mode=%b c0=%b sum=%h lz=%h required ill=1 mode=11 c0=0 sum=123 lz0=39",
                        out_illegal, out_mode, out_carry[0], out_sum, out_lz);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL directed_idle: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    beat_t ea[3];
    logic  acc;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(2'(i), 48'(48'h1000 * (i + 1)), 48'h77, 48'(i + 9), 2'b10, 32'(100 + i));
      ea[i] = model(in_mode, in_sum, in_carry, in_addend, in_sub, in_side);
      in_valid = 1'b1;
      step();
      if (i == 1) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++; $display("FAIL bp_ready_low: in_ready=%b required 0 after two beats held", in_ready);
        end
      end
    end
    step();
    n_cmp++;
    if ({out_valid, cur_out()} !== {1'b1, ea[0]}) begin
      n_bad++; $display("FAIL bp_stable: v=%b out=%h required v=1 out=%h", out_valid, cur_out(), ea[0]);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got_q.size() < 3; cyc++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    step(); step();
    n_cmp++;
    if (got_q.size() != 3) begin
      n_bad++; $display("FAIL bp_count: got %0d beats required 3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== ea[i]) begin
        n_bad++; $display("FAIL bp_order[%0d]: got %h required %h", i, got_q[i], ea[i]);
      end
    end
  endtask

  task automatic test_flush();
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    for (int held = 2; held >= 1; held--) begin
      for (int i = 0; i < held; i++) begin
        rand_beat(); in_valid = 1'b1;
        step();
      end
      rand_beat(); in_valid = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_bad++; $display("FAIL flush_%0d: valid/ready=%b required 01", held, {out_valid, in_ready});
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++; $display("FAIL flush_leak: %0d beats emerged required 0", got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_beat(); in_valid = 1'b1;
      if (!in_ready) stalls++;
      step();
    end
    in_valid = 1'b0;
    step(); step();
    n_cmp++;
    if (stalls != 0 || got_q.size() != 20) begin
      n_bad++; $display("FAIL b2b_rate: stalls=%0d beats=%0d required 0 and 20", stalls, got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL b2b[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int   sent;
    logic acc;
    sent = 0; acc = 1'b0;
    exp_q.delete(); got_q.delete();
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 3000 && sent < 300; cyc++) begin
      if (!in_valid || acc) begin
        if ($urandom_range(3) != 0) begin rand_beat(); in_valid = 1'b1; end
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(2) != 0);
      acc = in_valid && in_ready;
      if (acc) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && got_q.size() < sent; cyc++) step();
    n_cmp++;
    if (got_q.size() != sent || exp_q.size() != sent) begin
      n_bad++; $display("FAIL rand_count: got %0d modelled %0d required %0d", got_q.size(), exp_q.size(), sent);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL rand[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rst_midstall();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_beat(2'b11, 48'hFFFF_0000_1234, 48'h5, {48{1'b1}}, 2'b11, 32'hDEAD_0000 + 32'(i));
      in_valid = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, cur_out()} !== {2'b00, beat_t'(0)}) begin
      n_bad++; $display("FAIL rst_mid: v=%b rdy=%b out=%h required all 0", out_valid, in_ready, cur_out());
    end
    rst = 1'b0;
    out_ready = 1'b1;
    step(); step();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL rst_mid_after: valid/ready=%b required 01", {out_valid, in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random();
    test_rst_midstall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
